// File: rtl/bp_stall_profiler_ctrl_if.sv
// Request/readout bundle of the stall profiler.
// The master drives the profiling inputs and the readout ready; the slave is the profiler.
interface bp_stall_profiler_ctrl_if #(
  parameter int ctr_width_p = 32
);
  logic                   en_i;
  logic                   commit_v_i;
  logic [29:0]            stall_reason_i;
  logic                   dump_req_i;
  logic                   clear_req_i;
  logic                   busy_o;
  logic                   dump_v_o;
  logic                   dump_ready_i;
  logic [4:0]             dump_idx_o;
  logic [ctr_width_p-1:0] dump_data_o;
  logic [15:0]            dropped_o;

  modport master (
    output en_i, commit_v_i, stall_reason_i, dump_req_i, clear_req_i, dump_ready_i,
    input  busy_o, dump_v_o, dump_idx_o, dump_data_o, dropped_o
  );

  modport slave (
    input  en_i, commit_v_i, stall_reason_i, dump_req_i, clear_req_i, dump_ready_i,
    output busy_o, dump_v_o, dump_idx_o, dump_data_o, dropped_o
  );
endinterface

// File: rtl/bp_stall_profiler_ctrl.sv
// Stall-reason profiler: 32 saturating counters (30 stall reasons, commits, enabled cycles)
// with a frozen-snapshot readout stream and an optional clear chained after the dump.
module bp_stall_profiler_ctrl #(
  parameter int ctr_width_p = 32
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  bp_stall_profiler_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DUMP  = 2'd1,
    DRAIN = 2'd2,
    CLEAR = 2'd3
  } state_t;

  localparam logic [ctr_width_p-1:0] ctr_one_c = {{(ctr_width_p-1){1'b0}}, 1'b1};

  state_t                        state_reg;
  logic [4:0]                    idx_reg;
  logic                          pend_reg;
  logic                          busy_reg;
  logic                          dump_v_reg;
  logic [15:0]                   dropped_reg;
  logic [31:0][ctr_width_p-1:0]  ctr_reg;
  logic [31:0][ctr_width_p-1:0]  ctr_next;
  logic [31:0]                   inc;
  logic [4:0]                    hi_sel;
  logic                          counted;

  // Highest set reason bit wins; no bit set falls back to entry 0 (unknown).
  always_comb begin
    hi_sel = 5'd0;
    for (int i = 0; i < 30; i++) begin
      if (bus.stall_reason_i[i]) begin
        hi_sel = 5'(i);
      end
    end
  end

  assign counted = bus.en_i && (state_reg == IDLE);

  genvar gi;
  generate
    for (gi = 0; gi < 32; gi++) begin : g_ctr
      if (gi < 30) begin : g_stall
        assign inc[gi] = counted && !bus.commit_v_i && (hi_sel == 5'(gi));
      end else if (gi == 30) begin : g_commit
        assign inc[gi] = counted && bus.commit_v_i;
      end else begin : g_total
        assign inc[gi] = counted;
      end

      assign ctr_next[gi] = (state_reg == CLEAR)                    ? '0 :
                            (inc[gi] && (ctr_reg[gi] != '1))        ? ctr_reg[gi] + ctr_one_c :
                                                                      ctr_reg[gi];
    end
  endgenerate

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      ctr_reg <= '0;
    end else begin
      ctr_reg <= ctr_next;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_reg   <= IDLE;
      idx_reg     <= 5'd0;
      pend_reg    <= 1'b0;
      busy_reg    <= 1'b0;
      dump_v_reg  <= 1'b0;
      dropped_reg <= 16'd0;
    end else begin
      if (state_reg == CLEAR) begin
        dropped_reg <= 16'd0;
      end else if ((state_reg != IDLE) && bus.en_i && (dropped_reg != 16'hFFFF)) begin
        dropped_reg <= dropped_reg + 16'd1;
      end

      case (state_reg)
        IDLE: begin
          if (bus.dump_req_i) begin
            state_reg  <= DUMP;
            idx_reg    <= 5'd0;
            pend_reg   <= bus.clear_req_i;
            busy_reg   <= 1'b1;
            dump_v_reg <= 1'b1;
          end else if (bus.clear_req_i) begin
            state_reg <= CLEAR;
            busy_reg  <= 1'b1;
          end
        end
        DUMP: begin
          if (bus.dump_ready_i) begin
            if (idx_reg == 5'd31) begin
              state_reg  <= DRAIN;
              idx_reg    <= 5'd0;
              dump_v_reg <= 1'b0;
            end else begin
              idx_reg <= idx_reg + 5'd1;
            end
          end
        end
        DRAIN: begin
          if (pend_reg) begin
            state_reg <= CLEAR;
          end else begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
          end
        end
        CLEAR: begin
          state_reg <= IDLE;
          pend_reg  <= 1'b0;
          busy_reg  <= 1'b0;
        end
        default: begin
          state_reg  <= IDLE;
          busy_reg   <= 1'b0;
          dump_v_reg <= 1'b0;
        end
      endcase
    end
  end

  // Counters are frozen outside IDLE, so a direct mux of the bank is a stable snapshot.
  assign bus.busy_o      = busy_reg;
  assign bus.dump_v_o    = dump_v_reg;
  assign bus.dump_idx_o  = idx_reg;
  assign bus.dump_data_o = ctr_reg[idx_reg];
  assign bus.dropped_o   = dropped_reg;

endmodule

// File: doc/bp_stall_profiler_ctrl.md
BP_STALL_PROFILER_CTRL -- requirements
Module: bp_stall_profiler_ctrl

Interface
REQ-001 Parameter ctr_width_p, default 32, SHALL set the width of each counter in bits; legal range 8..64.
REQ-002 Port aclk, input, 1: SHALL be the single clock; all state updates on its rising edge.
REQ-003 Port aresetn, input, 1: SHALL be the reset, asynchronous and active-low.
REQ-004 Port en_i, input, 1: SHALL enable counting when high.
REQ-005 Port commit_v_i, input, 1: SHALL indicate an instruction committed this cycle.
REQ-006 Port stall_reason_i, input, 30: SHALL carry raw stall-reason flags; bit n equals stall-reason code n (29 = ic_miss down to 0 = unknown).
REQ-007 Port dump_req_i, input, 1: SHALL request a readout of all counters.
REQ-008 Port clear_req_i, input, 1: SHALL request zeroing of all counters.
REQ-009 Port busy_o, output, 1: SHALL be high whenever state is not IDLE.
REQ-010 Port dump_v_o, output, 1: SHALL flag a valid readout beat.
REQ-011 Port dump_ready_i, input, 1: SHALL accept a readout beat.
REQ-012 Port dump_idx_o, output, 5: SHALL give the counter index of the current beat.
REQ-013 Port dump_data_o, output, ctr_width_p: SHALL give the counter value of the current beat.
REQ-014 Port dropped_o, output, 16: SHALL give the saturating count of cycles that were not counted while busy.

Function
REQ-015 The counter bank SHALL hold 32 entries: 0..29 = stall reasons, 30 = commits, 31 = total enabled cycles.
REQ-016 A counted cycle SHALL be one where en_i=1 and the state is IDLE.
REQ-017 On a counted cycle, entry 31 SHALL increment.
REQ-018 On a counted cycle with commit_v_i=1, entry 30 SHALL increment and no stall entry SHALL change.
REQ-019 On a counted cycle with commit_v_i=0, exactly one stall entry SHALL increment: the highest set bit index of stall_reason_i, or entry 0 (unknown) if no bit is set.
REQ-020 All counters SHALL saturate at all-ones and SHALL never wrap.
REQ-021 The FSM states SHALL be IDLE, DUMP, DRAIN and CLEAR.
REQ-022 IDLE SHALL go to DUMP on dump_req_i=1, else to CLEAR on clear_req_i=1.
REQ-023 If dump_req_i and clear_req_i are both high in IDLE, the FSM SHALL go to DUMP and SHALL latch a pending clear.
REQ-024 In DUMP, dump_v_o SHALL be 1, dump_idx_o SHALL equal an internal index starting at 0, and dump_data_o SHALL equal entry[index].
REQ-025 Data and index SHALL be held stable while dump_v_o=1 and dump_ready_i=0.
REQ-026 On handshake (dump_v_o & dump_ready_i) the index SHALL increment.
REQ-027 On the handshake at index 31 the FSM SHALL go to DRAIN.
REQ-028 DRAIN SHALL last one cycle with dump_v_o=0, then go to CLEAR if a clear is pending, else to IDLE.
REQ-029 CLEAR SHALL zero all 32 counters in one cycle, clear the pending flag, and return to IDLE.
REQ-030 Counters SHALL be frozen in DUMP, DRAIN and CLEAR, so a dump is a consistent snapshot.
REQ-031 In any non-IDLE cycle with en_i=1, dropped_o SHALL increment, saturating at 0xFFFF.
REQ-032 CLEAR SHALL also zero dropped_o.
REQ-033 Requests arriving in non-IDLE states SHALL be ignored; requests are levels sampled only in IDLE.
REQ-034 Readout latency SHALL be 1 cycle from the dump request to the first dump_v_o=1.
REQ-035 A full dump with dump_ready_i held at 1 SHALL take 32 beats.

Reset
REQ-036 When aresetn=0, all counters, dropped_o, the index and the pending flag SHALL be 0, the state SHALL be IDLE, and busy_o and dump_v_o SHALL be 0.
REQ-037 Reset asserted mid-dump or mid-clear SHALL abort immediately; no further beats SHALL be issued after release.

Verification
REQ-038 Scenario (priority): 10 cycles with en_i=1, commit_v_i=0, stall_reason_i bits 29 and 2 set, then dump -> entry 29 = 10, entry 2 = 0, entry 31 = 10.
REQ-039 Scenario (commit and unknown): 5 commit cycles plus 3 cycles with stall_reason_i=0 -> entry 30 = 5, entry 0 = 3, entry 31 = 8.
REQ-040 Scenario (backpressure): dump with dump_ready_i toggling every cycle -> 32 beats, indices 0..31 in order, data stable while stalled, busy_o drops after DRAIN.
REQ-041 Scenario (dump plus clear): dump_req_i and clear_req_i raised together -> 32 beats with the pre-clear values, then all counters = 0; a second dump reads all zeros; dropped_o = 0.
REQ-042 Scenario (saturation): ctr_width_p=8, 300 stall cycles on bit 5 -> entry 5 = 255, entry 31 = 255.
REQ-043 Scenario (reset mid-dump): aresetn dropped after beat 10 -> dump_v_o=0 and counters=0 after release; a new dump starts at index 0.
